// File: rtl/mux_rr_arbiter_if.sv
// Bundles the request/grant/select signals shared between the round-robin
// arbiter and the logic that drives its requests and consumes its selects.
interface mux_rr_arbiter_if #(
  parameter int CW = 4
);
  logic [3:0]    req;
  logic [3:0]    gnt;
  logic          s0;
  logic          s1;
  logic          sel_valid;
  logic [CW-1:0] hold_cnt;

  modport master (
    input  req,
    output gnt, s0, s1, sel_valid, hold_cnt
  );

  modport slave (
    output req,
    input  gnt, s0, s1, sel_valid, hold_cnt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux: one-hot grant, registered select
// pair {s0,s1}, and a hold limit that bounds every tenure to MAX_HOLD cycles.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux_rr_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    owner;
  logic [CW-1:0] hold_q;
  logic [3:0]    gnt_q;
  logic [1:0]    sel_q;
  logic          valid_q;

  logic [1:0]    arb_ptr;
  logic [1:0]    winner;

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // On release the owner becomes lowest priority, so re-arbitration in the
  // same cycle must already use the advanced pointer.
  always_comb begin
    arb_ptr = (state == GRANT) ? owner + 2'd1 : ptr;
    winner  = pick(bus.req, arb_ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      owner   <= 2'd0;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state   <= GRANT;
            owner   <= winner;
            gnt_q   <= 4'b0001 << winner;
            sel_q   <= winner;
            valid_q <= 1'b1;
            hold_q  <= ONE;
          end
        end
        GRANT: begin
          if (bus.req[owner] && hold_q < HOLD_MAX) begin
            hold_q <= hold_q + ONE;
          end else begin
            ptr <= owner + 2'd1;
            if (|bus.req) begin
              owner   <= winner;
              gnt_q   <= 4'b0001 << winner;
              sel_q   <= winner;
              valid_q <= 1'b1;
              hold_q  <= ONE;
            end else begin
              state   <= IDLE;
              gnt_q   <= 4'b0000;
              valid_q <= 1'b0;
              hold_q  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.s0        = sel_q[1];
  assign bus.s1        = sel_q[0];
  assign bus.sel_valid = valid_q;
  assign bus.hold_cnt  = hold_q;

endmodule
